// File: rtl/bitmap_pkg.sv
// Shared sizing helpers for the bitmap fetch family: log2 sizing, lane and word-address widths.
package bitmap_pkg;

    function automatic int clog2(input longint v);
        int     r;
        longint p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int pix_per_word(input int word_w, input int bpp);
        return word_w / bpp;
    endfunction

    // A one-pixel word still gets a 1-bit lane so every port keeps a legal width.
    function automatic int lane_w(input int word_w, input int bpp);
        return (word_w / bpp > 1) ? clog2(longint'(word_w / bpp)) : 1;
    endfunction

    function automatic int addr_w(input int bm_w, input int bm_h, input int bpp, input int word_w);
        longint words;
        words = (longint'(bm_w) * bm_h * bpp + word_w - 1) / word_w;
        return (words > 1) ? clog2(words) : 1;
    endfunction

    localparam int PIX_PER_WORD = pix_per_word(32, 1);
    localparam int LANE_W       = lane_w(32, 1);
    localparam int ADDR_W       = addr_w(640, 480, 1, 32);

endpackage

// File: rtl/bitmap_pixel_fetch_if.sv
// Coordinate-in, RAM-read and pixel-out signals of the bitmap fetch; master = fetch block.
interface bitmap_pixel_fetch_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int BPP    = 1,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [X_W-1:0]    in_x;
    logic [Y_W-1:0]    in_y;
    logic [X_W-1:0]    org_x;
    logic [Y_W-1:0]    org_y;
    logic [1:0]        scale_log2;
    logic              mirror_x;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [BPP-1:0]    out_pixel;
    logic              out_hit;

    modport master (
        input  in_valid, in_x, in_y, org_x, org_y, scale_log2, mirror_x,
        input  mem_rdata, out_ready,
        output in_ready, mem_rd_en, mem_addr, out_valid, out_pixel, out_hit
    );

    modport slave (
        output in_valid, in_x, in_y, org_x, org_y, scale_log2, mirror_x,
        output mem_rdata, out_ready,
        input  in_ready, mem_rd_en, mem_addr, out_valid, out_pixel, out_hit
    );
endinterface

// File: rtl/bitmap_lane_extract.sv
// Combinational WORD_W -> BPP lane mux; lane 0 is the most significant pixel of the word.
module bitmap_lane_extract
    import bitmap_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BPP    = 1,
    localparam int LW    = lane_w(WORD_W, BPP),
    localparam int PPW   = pix_per_word(WORD_W, BPP)
) (
    input  logic [WORD_W-1:0] word,
    input  logic [LW-1:0]     lane,
    output logic [BPP-1:0]    pixel
);
    logic [LW-1:0] rev_lane;

    always_comb begin
        rev_lane = LW'(PPW - 1) - lane;
        pixel    = BPP'(word >> (int'(rev_lane) * BPP));
    end
endmodule

// File: rtl/bitmap_pixel_fetch.sv
// Screen coordinate -> bitmap pixel via external sync RAM; 3 cycles accept-to-out_valid, 1/clk.
// One global advance: every stage holds while out_valid && !out_ready, and RAM reads hold with it.
module bitmap_pixel_fetch
    import bitmap_pkg::*;
#(
    parameter int BM_W   = 640,
    parameter int BM_H   = 480,
    parameter int BPP    = 1,
    parameter int WORD_W = 32,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitmap_pixel_fetch_if.master  bus
);
    localparam int ADDR_W = addr_w(BM_W, BM_H, BPP, WORD_W);
    localparam int IDX_W  = clog2(longint'(BM_W) * BM_H);
    localparam int PPW    = pix_per_word(WORD_W, BPP);
    localparam int SHIFT  = clog2(longint'(PPW));
    localparam int LW     = lane_w(WORD_W, BPP);

    localparam logic [X_W:0]   BMW_X  = (X_W+1)'(BM_W);
    localparam logic [Y_W:0]   BMH_Y  = (Y_W+1)'(BM_H);
    localparam logic [X_W-1:0] BMW_M1 = X_W'(BM_W - 1);

    logic adv;

    logic [X_W:0]   rel_x;
    logic [Y_W:0]   rel_y;
    logic [X_W-1:0] rx_sh, rx0;
    logic [Y_W-1:0] ry_sh;
    logic           hit0;

    logic           s1_valid, s1_hit;
    logic [X_W-1:0] s1_rx;
    logic [Y_W-1:0] s1_ry;
    logic [IDX_W-1:0] pix_idx;
    logic [LW-1:0]  lane1;

    logic           s2_valid, s2_hit;
    logic [LW-1:0]  s2_lane;
    logic [BPP-1:0] s2_pix;

    logic           out_valid_q, out_hit_q;
    logic [BPP-1:0] out_pixel_q;

    assign adv = !out_valid_q || bus.out_ready;

    // Subtraction carries one extra bit so a coordinate left of / above the origin is a miss, never a wrap.
    always_comb begin
        rel_x = {1'b0, bus.in_x} - {1'b0, bus.org_x};
        rel_y = {1'b0, bus.in_y} - {1'b0, bus.org_y};
        rx_sh = rel_x[X_W-1:0] >> bus.scale_log2;
        ry_sh = rel_y[Y_W-1:0] >> bus.scale_log2;
        hit0  = !rel_x[X_W] && !rel_y[Y_W] &&
                ({1'b0, rx_sh} < BMW_X) && ({1'b0, ry_sh} < BMH_Y);
        rx0   = bus.mirror_x ? (BMW_M1 - rx_sh) : rx_sh;
    end

    always_comb begin
        pix_idx = IDX_W'(s1_ry) * IDX_W'(BM_W) + IDX_W'(s1_rx);
        lane1   = LW'(pix_idx & IDX_W'(PPW - 1));
    end

    bitmap_lane_extract #(
        .WORD_W (WORD_W),
        .BPP    (BPP)
    ) u_lane (
        .word  (bus.mem_rdata),
        .lane  (s2_lane),
        .pixel (s2_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_hit      <= 1'b0;
            s1_rx       <= '0;
            s1_ry       <= '0;
            s2_valid    <= 1'b0;
            s2_hit      <= 1'b0;
            s2_lane     <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_pixel_q <= '0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            s1_hit      <= bus.in_valid && hit0;
            s1_rx       <= rx0;
            s1_ry       <= ry_sh;
            s2_valid    <= s1_valid;
            s2_hit      <= s1_valid && s1_hit;
            s2_lane     <= lane1;
            out_valid_q <= s2_valid;
            out_hit_q   <= s2_valid && s2_hit;
            out_pixel_q <= (s2_valid && s2_hit) ? s2_pix : '0;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.mem_rd_en = s1_valid && s1_hit && adv;
    assign bus.mem_addr  = ADDR_W'(pix_idx >> SHIFT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_pixel = out_pixel_q;
endmodule

// File: tb/tb_bitmap_pixel_fetch.sv
// Directed bench for bitmap_pixel_fetch: 1-bpp default build plus a 4-bpp build.
module tb_bitmap_pixel_fetch;
    import bitmap_pkg::*;

    localparam int AW1 = addr_w(640, 480, 1, 32);
    localparam int AW4 = addr_w(640, 480, 4, 32);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bitmap_pixel_fetch_if #(.X_W(10), .Y_W(9), .BPP(1), .WORD_W(32), .ADDR_W(AW1)) bus ();
    bitmap_pixel_fetch_if #(.X_W(10), .Y_W(9), .BPP(4), .WORD_W(32), .ADDR_W(AW4)) bus4 ();

    bitmap_pixel_fetch #(.BM_W(640), .BM_H(480), .BPP(1), .WORD_W(32), .X_W(10), .Y_W(9))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    bitmap_pixel_fetch #(.BM_W(640), .BM_H(480), .BPP(4), .WORD_W(32), .X_W(10), .Y_W(9))
        dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    logic [31:0] ram1 [0:16383];
    logic [31:0] ram4 [0:15];

    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram1[bus.mem_addr];
    always @(posedge clk)
        if (bus4.mem_rd_en) bus4.mem_rdata <= (bus4.mem_addr < 16) ? ram4[bus4.mem_addr[3:0]] : 32'h0;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [9:0]  ox;
        logic [8:0]  oy;
        logic [1:0]  sc;
        logic        mir;
        logic        hit;
        logic [13:0] addr;
        logic        pix;
    } vec_t;

    vec_t vt [16];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_x       = v.x;
        bus.in_y       = v.y;
        bus.org_x      = v.ox;
        bus.org_y      = v.oy;
        bus.scale_log2 = v.sc;
        bus.mirror_x   = v.mir;
    endtask

    task automatic run_vec(input int i);
        drive(vt[i]);
        bus.in_valid = 1'b1;
        chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk($sformatf("vec%0d_rd_en", i), 32'(bus.mem_rd_en), 32'(vt[i].hit));
        if (vt[i].hit) chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vt[i].addr));
        @(posedge clk); #1;
        chk($sformatf("vec%0d_early", i), 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_out", i), 32'({bus.out_valid, bus.out_hit, bus.out_pixel}),
            32'({1'b1, vt[i].hit, vt[i].pix}));
    endtask

    task automatic run_stream(input bit stall, input string tag);
        int   sent, got, rd_bad, unstable, stalls;
        logic prev_st, prev_hit, prev_pix;
        logic got_hit [10];
        logic got_pix [10];
        sent = 0; got = 0; rd_bad = 0; unstable = 0; stalls = 0;
        prev_st = 1'b0; prev_hit = 1'b0; prev_pix = 1'b0;
        for (int k = 0; k < 10; k++) begin got_hit[k] = 1'bx; got_pix[k] = 1'bx; end
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            bus.out_ready = !(stall && cyc >= 4 && cyc <= 8);
            if (sent < 10) begin
                drive(vt[sent]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (prev_st && ({bus.out_hit, bus.out_pixel} != {prev_hit, prev_pix})) unstable++;
            prev_st  = bus.out_valid && !bus.out_ready;
            prev_hit = bus.out_hit;
            prev_pix = bus.out_pixel;
            if (prev_st) begin
                stalls++;
                if (bus.mem_rd_en) rd_bad++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (got < 10) begin
                    got_hit[got] = bus.out_hit;
                    got_pix[got] = bus.out_pixel;
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, "_count"}, 32'(got), 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("%s_item%0d", tag, k), 32'({got_hit[k], got_pix[k]}),
                32'({vt[k].hit, vt[k].pix}));
        chk({tag, "_stall_cycles"}, 32'(stalls), stall ? 32'd5 : 32'd0);
        chk({tag, "_rd_in_stall"}, 32'(rd_bad), 32'd0);
        chk({tag, "_out_stable"}, 32'(unstable), 32'd0);
    endtask

    task automatic run4(input logic [9:0] x, input logic [15:0] exp_addr, input logic [3:0] exp_pix);
        bus4.in_x     = x;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        chk($sformatf("bpp4_x%0d_rd", x), 32'({bus4.mem_rd_en, bus4.mem_addr}), 32'({1'b1, exp_addr}));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk($sformatf("bpp4_x%0d_out", x), 32'({bus4.out_valid, bus4.out_hit, bus4.out_pixel}),
            32'({1'b1, 1'b1, exp_pix}));
    endtask

    initial begin
        int leak;
        //              x      y       ox      oy     sc    mir   hit   addr       pix
        vt[0]  = '{10'd33,   9'd0,   10'd0,   9'd0,  2'd0, 1'b0, 1'b1, 14'd1,    1'b1};
        vt[1]  = '{10'd0,    9'd1,   10'd0,   9'd0,  2'd0, 1'b0, 1'b1, 14'd20,   1'b1};
        vt[2]  = '{10'd640,  9'd0,   10'd0,   9'd0,  2'd0, 1'b0, 1'b0, 14'd0,    1'b0};
        vt[3]  = '{10'd639,  9'd479, 10'd0,   9'd0,  2'd0, 1'b0, 1'b1, 14'd9599, 1'b1};
        vt[4]  = '{10'd103,  9'd51,  10'd100, 9'd50, 2'd1, 1'b0, 1'b1, 14'd0,    1'b1};
        vt[5]  = '{10'd100,  9'd50,  10'd100, 9'd50, 2'd1, 1'b0, 1'b1, 14'd0,    1'b0};
        vt[6]  = '{10'd99,   9'd60,  10'd100, 9'd50, 2'd1, 1'b0, 1'b0, 14'd0,    1'b0};
        vt[7]  = '{10'd100,  9'd50,  10'd100, 9'd50, 2'd1, 1'b1, 1'b1, 14'd19,   1'b1};
        vt[8]  = '{10'd739,  9'd0,   10'd100, 9'd0,  2'd0, 1'b0, 1'b1, 14'd19,   1'b1};
        vt[9]  = '{10'd740,  9'd0,   10'd100, 9'd0,  2'd0, 1'b0, 1'b0, 14'd0,    1'b0};
        vt[10] = '{10'd47,   9'd11,  10'd0,   9'd0,  2'd3, 1'b0, 1'b1, 14'd20,   1'b1};
        vt[11] = '{10'd5,    9'd49,  10'd0,   9'd50, 2'd0, 1'b0, 1'b0, 14'd0,    1'b0};
        vt[12] = '{10'd0,    9'd479, 10'd0,   9'd0,  2'd0, 1'b0, 1'b1, 14'd9580, 1'b0};
        vt[13] = '{10'd0,    9'd480 - 9'd0, 10'd0, 9'd0, 2'd0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[14] = '{10'd1023, 9'd0,   10'd0,   9'd0,  2'd2, 1'b0, 1'b1, 14'd7,    1'b0};
        vt[15] = '{10'd1023, 9'd0,   10'd0,   9'd0,  2'd0, 1'b0, 1'b0, 14'd0,    1'b0};

        for (int a = 0; a < 16384; a++) ram1[a] = 32'h0;
        ram1[0]    = 32'h4000_0000;
        ram1[1]    = 32'h4000_0000;
        ram1[7]    = 32'hFFFF_FFFE;
        ram1[19]   = 32'h0000_0001;
        ram1[20]   = 32'h8400_0000;
        ram1[9599] = 32'h0000_0001;
        for (int a = 0; a < 16; a++) ram4[a] = 32'h0;
        ram4[1] = 32'h5A50_0003;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drive(vt[0]);
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
        bus4.in_x = 10'd0; bus4.in_y = 9'd0; bus4.org_x = 10'd0; bus4.org_y = 9'd0;
        bus4.scale_log2 = 2'd0; bus4.mirror_x = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'({bus.out_valid, bus.out_hit, bus.out_pixel}), 32'd0);
        chk("reset_rd", 32'({bus.mem_rd_en, bus.mem_addr}), 32'd0);
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 16; i++) run_vec(i);

        // Three items in flight with the output blocked, then a one-cycle reset.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(vt[k == 2 ? 3 : k]);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("inflight_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk("midreset_state", 32'({bus.out_valid, bus.mem_rd_en, bus.in_ready}), 32'b001);
        leak = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) leak++;
        end
        chk("midreset_no_output", 32'(leak), 32'd0);
        @(posedge clk); #1;

        run_stream(1'b0, "stream");
        run_stream(1'b1, "stall");

        run4(10'd9,  16'd1, 4'hA);
        run4(10'd8,  16'd1, 4'h5);
        run4(10'd15, 16'd1, 4'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitmap_pixel_fetch.md
Name: bitmap_pixel_fetch

Overview:
- Parametrised, pipelined successor to the flat-array bitmap lookup.
- Maps a screen coordinate stream onto a bitmap held in external synchronous RAM (word-packed, BPP bits per pixel). Applies sprite origin offset, integer power-of-two scaling and optional horizontal mirror.
- Returns pixel value plus hit flag with valid/ready flow control.
- Sits between the VGA coordinate generator and the colour mux.

Parameters:
- BM_W, 640, bitmap width in pixels
- BM_H, 480, bitmap height in pixels
- BPP, 1, bits per pixel; power of two, ≤ WORD_W
- WORD_W, 32, RAM word width; power of two, multiple of BPP
- X_W, 10, screen x coordinate width
- Y_W, 9, screen y coordinate width
- ADDR_W, clog2(ceil(BM_W*BM_H*BPP/WORD_W)), RAM word address width (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  coordinate present
- in_ready  out  1  coordinate accepted when in_valid && in_ready
- in_x  in  X_W  screen x
- in_y  in  Y_W  screen y
- org_x  in  X_W  sprite origin x; sampled with the accepted coordinate
- org_y  in  Y_W  sprite origin y; sampled with the accepted coordinate
- scale_log2  in  2  scale factor = 2^scale_log2 (1..8)
- mirror_x  in  1  horizontal flip
- mem_rd_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM word address
- mem_rdata  in  WORD_W  RAM data, valid one cycle after mem_rd_en; held while mem_rd_en is low
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_pixel  out  BPP  pixel value; 0 when out_hit=0
- out_hit  out  1  coordinate fell inside the scaled bitmap

Behaviour:
- Reset (rst_n low at clk edge): all stage valids cleared; out_valid=0, out_pixel=0, out_hit=0, mem_rd_en=0, mem_addr=0. in_ready=1 from the first cycle after reset. A reset mid-stream discards all in-flight items; no output is produced for them.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift together on adv; on !adv every register holds.
- S0 (accept): rel_x = {0,in_x} − {0,org_x} and rel_y likewise, both (X_W+1)/(Y_W+1)-bit signed.
  - Negative rel → miss.
  - Otherwise rx = rel_x >> scale_log2, ry = rel_y >> scale_log2.
  - hit = rx < BM_W && ry < BM_H.
  - If mirror_x, rx := BM_W−1−rx, applied after the bounds check.
  - Registers rx, ry, hit, valid.
- S1 (address): pix_idx = ry*BM_W + rx, width clog2(BM_W*BM_H).
  - mem_addr = pix_idx >> clog2(WORD_W/BPP); lane = low bits.
  - mem_rd_en = s1_valid && s1_hit && adv. Misses issue no read.
  - Registers lane, hit, valid into S2.
- S2 (data): mem_rdata is valid for the S2 item. Pixel extraction is MSB-first: lane l occupies bits [WORD_W−1−l*BPP −: BPP].
- S3 (output): out_pixel = hit ? extracted : 0; out_hit = hit; out_valid = s2_valid.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput: 1 per clock.
- Stall correctness: because mem_rd_en is gated by adv, RAM output holds, so the S2 item's data stays valid across any stall length. No item is lost or duplicated.
- Simultaneous out_ready low and in_valid high: in_ready=0; the input must hold (standard valid/ready).
- org_x, org_y, scale_log2 and mirror_x are only sampled on acceptance; changes mid-stream affect later coordinates only.
- Boundaries:
  - rx = BM_W−1 → hit.
  - rx = BM_W → miss.
  - rel = −1 → miss; no wrap is allowed.

Decomposition:
- Package bitmap_pkg holds clog2 helper function, PIX_PER_WORD = WORD_W/BPP, LANE_W, and the derived ADDR_W formula.
- One sub-module, bitmap_lane_extract: combinational WORD_W → BPP lane mux, parametrised on WORD_W and BPP; reused by future multi-BPP sprite blocks.

Test Plan:
- Reset → out_valid=0, mem_rd_en=0, in_ready=1.
  - Then hold rst_n low one cycle with 3 items in flight → none emerge.
- Defaults, org=(0,0), scale 0, input (33,0) → mem_addr=1; rdata=0x4000_0000 → 3 cycles later out_pixel=1, out_hit=1.
  - Input (0,1) → mem_addr=20, lane 0 (bit 31).
- Misses:
  - (640,0) → out_hit=0, out_pixel=0, no mem_rd_en.
  - (639,479) → hit, mem_addr=9599, lane 31 (bit 0).
- org=(100,50), scale_log2=1:
  - (103,51) → rx=1, ry=0, mem_addr=0, lane 1.
  - (99,60) → miss.
  - Mirror on, (100,50) → rx=639.
- Back-to-back stream of 10 coordinates, out_ready low cycles 4–8 → outputs identical in order to the no-stall run; mem_rd_en=0 throughout the stall; out_pixel stable while out_valid && !out_ready.
- BPP=4, WORD_W=32 build: (9,0) → mem_addr=1, lane 1 → out_pixel = rdata[27:24].
